// File: rtl/fb_scanout_ctrl.sv
// fb_scanout_ctrl
// ----------------------------------------------------------------------------
// Schedules one framebuffer line fetch per displayed 480p line, one line ahead
// of the beam, and owns front/back buffer selection. A renderer swap request
// is applied only on the last clock of the last visible line. This keeps the
// displayed frame from tearing. It also means the line-0 fetch issued at the
// end of vertical blanking already reads from the new front buffer.
//
// Ports
//   clk_pix      in   pixel clock (sole clock)
//   reset        in   asynchronous, active-high reset
//   x, y         in   beam column / line from the timing generator
//   swap_req     in   level: back buffer is ready to be shown
//   swap_done    out  one-cycle pulse: swap applied
//   front_buf    out  buffer currently displayed (back buffer = ~front_buf)
//   fetch_req    out  line-fetch request to the memory arbiter
//   fetch_addr   out  start word address of the requested line
//   fetch_line   out  line number being fetched (0..V_ACTIVE-1)
//   fetch_ack    in   arbiter accepted the request (one cycle)
//   underrun_clr in   clears the sticky underrun flag
//   underrun     out  sticky: a fetch was still pending when the next was due
// ----------------------------------------------------------------------------
module fb_scanout_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 500,
  parameter int ADDR_W      = 20,
  parameter int LINE_STRIDE = 640,
  parameter int FB0_BASE    = 0,
  parameter int FB1_BASE    = 307200
) (
  input  logic              clk_pix,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_buf,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [8:0]        fetch_line,
  input  logic              fetch_ack,
  input  logic              underrun_clr,
  output logic              underrun
);

  localparam logic [9:0]        X_TRIG     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        X_SWAP     = 10'(H_TOTAL - 1);
  localparam logic [9:0]        Y_LAST_VIS = 10'(V_ACTIVE - 1);
  localparam logic [9:0]        Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] BASE0_C    = ADDR_W'(FB0_BASE);
  localparam logic [ADDR_W-1:0] BASE1_C    = ADDR_W'(FB1_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_C   = ADDR_W'(LINE_STRIDE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        line_q, line_d;
  logic              front_q, front_d;
  logic              done_q, done_d;
  logic              unr_q, unr_d;

  logic              trig_s;
  logic              swap_s;
  logic              unr_set_s;
  logic [8:0]        target_s;
  logic [ADDR_W-1:0] base_s;
  logic [ADDR_W-1:0] addr_s;

  // Decode fetch trigger, its target line/address and the swap event from the beam position.
  always_comb begin
    trig_s = (x == X_TRIG) && ((y < Y_LAST_VIS) || (y == Y_LAST));
    // The last blanking line prefetches line 0 of the next frame.
    if (y == Y_LAST) begin
      target_s = 9'd0;
    end else begin
      target_s = 9'(y + 10'd1);
    end
    base_s    = front_q ? BASE1_C : BASE0_C;
    addr_s    = base_s + (ADDR_W'(target_s) * STRIDE_C);
    swap_s    = (x == X_SWAP) && (y == Y_LAST_VIS) && swap_req;
    // A new trigger while the old request is still unacknowledged is an underrun.
    unr_set_s = (state_q == ST_REQ) && trig_s && !fetch_ack;
  end

  // FSM state register.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a trigger always (re)enters REQ, even over a stale request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (trig_s) begin
          state_d = ST_REQ;
        end else if (fetch_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: the request is the REQ state itself.
  always_comb begin
    fetch_req = 1'b0;
    case (state_q)
      ST_IDLE: fetch_req = 1'b0;
      ST_REQ:  fetch_req = 1'b1;
      default: fetch_req = 1'b0;
    endcase
  end

  // Next values for the fetch descriptor, buffer select, swap pulse and underrun flag.
  always_comb begin
    if (trig_s) begin
      line_d = target_s;
      addr_d = addr_s;
    end else begin
      line_d = line_q;
      addr_d = addr_q;
    end

    if (swap_s) begin
      front_d = ~front_q;
    end else begin
      front_d = front_q;
    end
    done_d = swap_s;

    // Set has priority over clear.
    if (unr_set_s) begin
      unr_d = 1'b1;
    end else if (underrun_clr) begin
      unr_d = 1'b0;
    end else begin
      unr_d = unr_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      line_q  <= 9'd0;
      front_q <= 1'b0;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      line_q  <= line_d;
      front_q <= front_d;
      done_q  <= done_d;
      unr_q   <= unr_d;
    end
  end

  assign fetch_addr = addr_q;
  assign fetch_line = line_q;
  assign front_buf  = front_q;
  assign swap_done  = done_q;
  assign underrun   = unr_q;

endmodule

// File: tb/tb_fb_scanout_ctrl.sv
// Testbench for fb_scanout_ctrl. The beam position is driven directly (only the
// interesting columns of each line are visited) and every cycle is compared
// against a transaction-level reference model of the fetch/swap rules.
module tb_fb_scanout_ctrl;

  logic        clk_pix = 1'b0;
  logic        reset;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        swap_req;
  logic        swap_done;
  logic        front_buf;
  logic        fetch_req;
  logic [19:0] fetch_addr;
  logic [8:0]  fetch_line;
  logic        fetch_ack;
  logic        underrun_clr;
  logic        underrun;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_req, m_line, m_addr, m_front, m_done, m_unr;

  // observation counters
  int cyc      = 0;
  int rises    = 0;
  bit prev_req = 1'b0;
  int done_cnt = 0;
  int done_at  = 0;
  int done_gap = 0;

  always #5 clk_pix = ~clk_pix;

  fb_scanout_ctrl dut (
    .clk_pix      (clk_pix),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .swap_req     (swap_req),
    .swap_done    (swap_done),
    .front_buf    (front_buf),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_line   (fetch_line),
    .fetch_ack    (fetch_ack),
    .underrun_clr (underrun_clr),
    .underrun     (underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_line = 0; m_addr = 0; m_front = 0; m_done = 0; m_unr = 0;
  endtask

  // One pixel clock of the rules: which line is due, from which buffer,
  // whether a pending request was overtaken, and whether a swap happens.
  task automatic model_step(input int xx, input int yy, input bit ack, input bit sreq, input bit clr);
    bit trig;
    int tgt;
    trig = (xx == 639) && ((yy < 479) || (yy == 499));
    tgt  = (yy == 499) ? 0 : yy + 1;
    if (trig && (m_req != 0) && !ack) m_unr = 1;
    else if (clr)                     m_unr = 0;
    if (trig) begin
      m_line = tgt;
      m_addr = ((m_front != 0) ? 307200 : 0) + tgt * 640;
      m_req  = 1;
    end else if (ack) begin
      m_req = 0;
    end
    m_done = (xx == 799 && yy == 479 && sreq) ? 1 : 0;
    if (m_done != 0) m_front = 1 - m_front;
  endtask

  task automatic check_all();
    check_eq("fetch_req",  32'(fetch_req),  32'(m_req));
    check_eq("fetch_line", 32'(fetch_line), 32'(m_line));
    check_eq("fetch_addr", 32'(fetch_addr), 32'(m_addr));
    check_eq("front_buf",  32'(front_buf),  32'(m_front));
    check_eq("swap_done",  32'(swap_done),  32'(m_done));
    check_eq("underrun",   32'(underrun),   32'(m_unr));
  endtask

  // Drive one cycle of inputs just after a falling edge, then check after the next one.
  task automatic cycle(input int xx, input int yy, input bit ack, input bit sreq, input bit clr);
    x            = 10'(xx);
    y            = 10'(yy);
    fetch_ack    = ack;
    swap_req     = sreq;
    underrun_clr = clr;
    model_step(xx, yy, ack, sreq, clr);
    @(negedge clk_pix);
    cyc++;
    check_all();
    if (fetch_req && !prev_req) rises++;
    prev_req = fetch_req;
    if (swap_done) begin
      done_cnt++;
      done_gap = cyc - done_at;
      done_at  = cyc;
    end
  endtask

  // ack_mode: 0 ack two cycles after the trigger, 1 never, 2 random, 3 only on triggers.
  // sreq_mode: 0 low, 1 high, 2 high from line 100 until swap_done, 3 random.
  task automatic walk_frame(input int ack_mode, input int sreq_mode);
    int xs [5];
    bit dropped;
    bit ack, sreq, clr;
    xs = '{639, 640, 641, 642, 799};
    dropped = 1'b0;
    for (int yy = 0; yy < 500; yy++) begin
      for (int k = 0; k < 5; k++) begin
        case (ack_mode)
          0:       ack = (xs[k] == 641);
          1:       ack = 1'b0;
          2:       ack = ($urandom_range(0, 1) == 1);
          default: ack = (xs[k] == 639) && ((yy < 479) || (yy == 499));
        endcase
        case (sreq_mode)
          0:       sreq = 1'b0;
          1:       sreq = 1'b1;
          2:       sreq = (yy >= 100) && !dropped;
          default: sreq = ($urandom_range(0, 1) == 1);
        endcase
        clr = (ack_mode == 2) && ($urandom_range(0, 7) == 0);
        cycle(xs[k], yy, ack, sreq, clr);
        if (swap_done) dropped = 1'b1;
        if (ack_mode == 2 && $urandom_range(0, 3) == 0) begin
          cycle(int'($urandom_range(0, 799)), int'($urandom_range(0, 499)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; x = 10'd0; y = 10'd0;
    swap_req = 1'b0; fetch_ack = 1'b0; underrun_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_pix);
    check_eq("rst_req",   32'(fetch_req),  32'd0);
    check_eq("rst_addr",  32'(fetch_addr), 32'd0);
    check_eq("rst_line",  32'(fetch_line), 32'd0);
    check_eq("rst_front", 32'(front_buf),  32'd0);
    check_eq("rst_done",  32'(swap_done),  32'd0);
    check_eq("rst_unr",   32'(underrun),   32'd0);
    reset = 1'b0;

    // free-running frame, prompt acks, no swap
    rises = 0;
    walk_frame(0, 0);
    check_eq("req_per_frame", 32'(rises),     32'd480);
    check_eq("frame0_unr",    32'(underrun),  32'd0);
    check_eq("frame0_front",  32'(front_buf), 32'd0);

    // directed fetch addresses
    cycle(639, 499, 1'b0, 1'b0, 1'b0);
    check_eq("line0_line", 32'(fetch_line), 32'd0);
    check_eq("line0_addr", 32'(fetch_addr), 32'd0);
    cycle(641, 499, 1'b1, 1'b0, 1'b0);
    cycle(639, 0, 1'b0, 1'b0, 1'b0);
    check_eq("line1_line", 32'(fetch_line), 32'd1);
    check_eq("line1_addr", 32'(fetch_addr), 32'd640);
    cycle(641, 0, 1'b1, 1'b0, 1'b0);
    cycle(639, 478, 1'b0, 1'b0, 1'b0);
    check_eq("line479_line", 32'(fetch_line), 32'd479);
    check_eq("line479_addr", 32'(fetch_addr), 32'd306560);
    cycle(641, 478, 1'b1, 1'b0, 1'b0);

    // underrun: no ack before the next trigger
    cycle(639, 499, 1'b0, 1'b0, 1'b0);
    cycle(700, 499, 1'b0, 1'b0, 1'b0);
    cycle(639, 0, 1'b0, 1'b0, 1'b0);
    check_eq("unr_set",  32'(underrun),   32'd1);
    check_eq("unr_req",  32'(fetch_req),  32'd1);
    check_eq("unr_line", 32'(fetch_line), 32'd1);
    check_eq("unr_addr", 32'(fetch_addr), 32'd640);
    cycle(100, 5, 1'b0, 1'b0, 1'b1);
    check_eq("unr_clr", 32'(underrun), 32'd0);
    cycle(639, 1, 1'b0, 1'b0, 1'b1);
    check_eq("unr_set_wins", 32'(underrun), 32'd1);
    // trigger and ack together: completes old, loads new, no underrun
    cycle(639, 2, 1'b1, 1'b0, 1'b1);
    check_eq("ackTrig_unr",  32'(underrun),   32'd0);
    check_eq("ackTrig_line", 32'(fetch_line), 32'd3);
    check_eq("ackTrig_addr", 32'(fetch_addr), 32'd1920);
    check_eq("ackTrig_req",  32'(fetch_req),  32'd1);
    cycle(640, 2, 1'b0, 1'b0, 1'b0);
    cycle(641, 2, 1'b1, 1'b0, 1'b0);

    // acks only on trigger cycles: request never drops, never underruns
    rises = 0;
    walk_frame(3, 0);
    check_eq("ackTrig_rises", 32'(rises),    32'd1);
    check_eq("ackTrig_nounr", 32'(underrun), 32'd0);
    cycle(100, 5, 1'b1, 1'b0, 1'b0);

    // one swap requested from line 100
    done_cnt = 0;
    walk_frame(0, 2);
    check_eq("swap_count", 32'(done_cnt),  32'd1);
    check_eq("swap_front", 32'(front_buf), 32'd1);
    cycle(639, 499, 1'b0, 1'b0, 1'b0);
    check_eq("fb1_line0_addr", 32'(fetch_addr), 32'd307200);
    cycle(641, 499, 1'b1, 1'b0, 1'b0);
    cycle(639, 0, 1'b0, 1'b0, 1'b0);
    check_eq("fb1_line1_addr", 32'(fetch_addr), 32'd307840);
    cycle(641, 0, 1'b1, 1'b0, 1'b0);

    // randomized frames
    walk_frame(2, 3);
    walk_frame(2, 3);

    // reset while requesting from buffer 1
    cycle(100, 5, 1'b1, 1'b0, 1'b1);
    if (m_front == 0) cycle(799, 479, 1'b0, 1'b1, 1'b0);
    cycle(639, 10, 1'b0, 1'b0, 1'b0);
    check_eq("prerst_front", 32'(front_buf), 32'd1);
    check_eq("prerst_req",   32'(fetch_req), 32'd1);
    swap_req = 1'b0; fetch_ack = 1'b0; underrun_clr = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("arst_req",   32'(fetch_req),  32'd0);
    check_eq("arst_addr",  32'(fetch_addr), 32'd0);
    check_eq("arst_line",  32'(fetch_line), 32'd0);
    check_eq("arst_front", 32'(front_buf),  32'd0);
    check_eq("arst_done",  32'(swap_done),  32'd0);
    check_eq("arst_unr",   32'(underrun),   32'd0);
    model_reset();
    prev_req = 1'b0;
    @(negedge clk_pix);
    reset = 1'b0;
    check_all();
    cycle(639, 499, 1'b0, 1'b0, 1'b0);
    check_eq("postrst_line", 32'(fetch_line), 32'd0);
    check_eq("postrst_addr", 32'(fetch_addr), 32'd0);
    check_eq("postrst_req",  32'(fetch_req),  32'd1);

    // swap_req held for two frames
    done_cnt = 0;
    walk_frame(0, 1);
    check_eq("swap2_first_cnt",   32'(done_cnt),  32'd1);
    check_eq("swap2_first_front", 32'(front_buf), 32'd1);
    walk_frame(0, 1);
    check_eq("swap2_cnt",   32'(done_cnt),  32'd2);
    check_eq("swap2_front", 32'(front_buf), 32'd0);
    check_eq("swap2_gap",   32'(done_gap),  32'd2500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
